// File: rtl/spram_ctrl_if.sv
// Request/response handshake bundle for spram_ctrl.
// The master drives the requests and accepts the responses; the slave is the controller.
interface spram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram_ctrl.sv
// Moore-FSM controller for a 32x8 single-port RAM with a shared tristate data bus.
// Define SPRAM_CTRL_INIT_EN to zero-fill the RAM after every reset.
module spram_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  spram_ctrl_if.slave bus,
  output logic        init_done,
  output logic        ram_cs,
  output logic        ram_wr,
  output logic [4:0]  ram_addr,
  inout  wire  [7:0]  ram_data
);

`ifdef SPRAM_CTRL_INIT_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD1, S_RD2, S_RESP, S_INIT} state_t;
  localparam state_t RST_STATE = S_INIT;
`else
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD1, S_RD2, S_RESP} state_t;
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       r_wr;
  logic [4:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;

  logic       w_cs;
  logic       w_wr;
  logic [4:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_ready;
  logic       w_rsp_valid;

`ifdef SPRAM_CTRL_INIT_EN
  logic [4:0] r_init_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef SPRAM_CTRL_INIT_EN
      r_init_cnt <= '0;
`endif
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_wr    <= bus.req_wr;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == S_RD2 && !r_wr) r_rdata <= ram_data;
`ifdef SPRAM_CTRL_INIT_EN
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 5'd1;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = bus.req_wr ? S_WRITE : S_RD1;
      S_WRITE: w_next = S_IDLE;
      S_RD1:   w_next = S_RD2;
      S_RD2:   w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
`ifdef SPRAM_CTRL_INIT_EN
      S_INIT:  if (r_init_cnt == 5'd31) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Every RAM-side output decodes from registered state alone.
  always_comb begin
    w_cs        = 1'b0;
    w_wr        = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_ready     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_WRITE: begin
        w_cs = 1'b1;
        w_wr = 1'b1;
      end
      S_RD1, S_RD2: w_cs = 1'b1;
      S_RESP:  w_rsp_valid = 1'b1;
`ifdef SPRAM_CTRL_INIT_EN
      S_INIT: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = r_init_cnt;
        w_wdata = '0;
      end
`endif
      default: ;
    endcase
  end

  assign ram_cs        = w_cs;
  assign ram_wr        = w_wr;
  assign ram_addr      = w_addr;
  assign ram_data      = w_wr ? w_wdata : 8'bzzzz_zzzz;
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rdata;

`ifdef SPRAM_CTRL_INIT_EN
  assign init_done = (r_state != S_INIT);
`else
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl with a behavioural 32x8 RAM on the shared bus.
module tb_spram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done;
  logic       ram_cs;
  logic       ram_wr;
  logic [4:0] ram_addr;
  wire  [7:0] ram_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef SPRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  spram_ctrl_if u_if ();

  spram_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (u_if.slave),
    .init_done (init_done),
    .ram_cs    (ram_cs),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  logic [7:0] mem [32];
  assign ram_data = (ram_cs && !ram_wr) ? mem[ram_addr] : 8'bzzzz_zzzz;
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_data;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!u_if.req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_ready_timeout", {31'd0, u_if.req_ready}, 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, 32'd32);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    u_if.req_valid = 1'b1;
    u_if.req_wr    = 1'b1;
    u_if.req_addr  = a;
    u_if.req_wdata = d;
    wait_ready();
    tick();
    u_if.req_valid = 1'b0;
    u_if.req_addr  = ~a;
    u_if.req_wdata = ~d;
    check("wr_cs",    {31'd0, ram_cs}, 32'd1);
    check("wr_we",    {31'd0, ram_wr}, 32'd1);
    check("wr_addr",  {27'd0, ram_addr}, {27'd0, a});
    check("wr_data",  {24'd0, ram_data}, {24'd0, d});
    check("wr_ready", {31'd0, u_if.req_ready}, 32'd0);
    tick();
  endtask

  // Read with rsp_ready held high; checks latency, data and return to IDLE.
  task automatic do_read(input logic [4:0] a, input logic [7:0] exp_d);
    int lat;
    u_if.rsp_ready = 1'b1;
    u_if.req_valid = 1'b1;
    u_if.req_wr    = 1'b0;
    u_if.req_addr  = a;
    wait_ready();
    tick();
    u_if.req_valid = 1'b0;
    u_if.req_addr  = ~a;
    lat = 1;
    while (!u_if.rsp_valid && lat < 10) begin
      check("rd_cs",   {31'd0, ram_cs}, 32'd1);
      check("rd_nodrv", {31'd0, ram_wr}, 32'd0);
      check("rd_addr", {27'd0, ram_addr}, {27'd0, a});
      tick();
      lat++;
    end
    check("rd_latency", lat, 32'd3);
    check("rd_data",    {24'd0, u_if.rsp_rdata}, {24'd0, exp_d});
    check("resp_cs",    {31'd0, ram_cs}, 32'd0);
    tick();
    check("rd_done_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("rd_done_ready", {31'd0, u_if.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.req_valid = 1'b0;
    u_if.req_wr    = 1'b0;
    u_if.req_addr  = '0;
    u_if.req_wdata = '0;
    u_if.rsp_ready = 1'b1;

    #1;
    check("rst_ready",     {31'd0, u_if.req_ready}, {31'd0, !INIT_EN});
    check("rst_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("rst_rdata",     {24'd0, u_if.rsp_rdata}, 32'd0);
    check("rst_cs",        {31'd0, ram_cs}, 32'd0);
    check("rst_we",        {31'd0, ram_wr}, 32'd0);
    check("rst_addr",      {27'd0, ram_addr}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, {31'd0, !INIT_EN});

    @(negedge clk);
    rst_n = 1'b1;
`ifdef SPRAM_CTRL_INIT_EN
    #1;
    check("init_cs0",   {31'd0, ram_cs}, 32'd1);
    check("init_we0",   {31'd0, ram_wr}, 32'd1);
    check("init_addr0", {27'd0, ram_addr}, 32'd0);
    wait_init("init_cycles");
    do_read(5'd0,  8'h00);
    do_read(5'd17, 8'h00);
    do_read(5'd31, 8'h00);
`else
    tick();
`endif

    do_write(5'd5, 8'hA3);
    do_read(5'd5, 8'hA3);

    // Backpressure on the response of addr 31.
    do_write(5'd31, 8'h5C);
    u_if.rsp_ready = 1'b0;
    u_if.req_valid = 1'b1;
    u_if.req_wr    = 1'b0;
    u_if.req_addr  = 5'd31;
    wait_ready();
    tick();
    u_if.req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, u_if.rsp_valid}, 32'd1);
      check("bp_data",  {24'd0, u_if.rsp_rdata}, 32'h5C);
      check("bp_ready", {31'd0, u_if.req_ready}, 32'd0);
      check("bp_cs",    {31'd0, ram_cs}, 32'd0);
      tick();
    end
    u_if.rsp_ready = 1'b1;
    tick();
    check("bp_rel_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, u_if.req_ready}, 32'd1);

    // Back-to-back writes with req_valid held: one acceptance every 2 cycles.
    u_if.req_valid = 1'b1;
    u_if.req_wr    = 1'b1;
    for (int a = 0; a < 32; a++) begin
      u_if.req_addr  = 5'(a);
      u_if.req_wdata = 8'(a);
      tick();
      check("b2b_we",    {31'd0, ram_wr}, 32'd1);
      check("b2b_addr",  {27'd0, ram_addr}, a);
      check("b2b_data",  {24'd0, ram_data}, a);
      tick();
      check("b2b_ready", {31'd0, u_if.req_ready}, 32'd1);
    end
    u_if.req_valid = 1'b0;
    for (int a = 0; a < 32; a++) do_read(5'(a), 8'(a));

    // Reset asserted while in RD2.
    u_if.req_valid = 1'b1;
    u_if.req_wr    = 1'b0;
    u_if.req_addr  = 5'd9;
    wait_ready();
    tick();
    u_if.req_valid = 1'b0;
    tick();
    check("rd2_cs", {31'd0, ram_cs}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs",    {31'd0, ram_cs}, 32'd0);
    check("mid_rst_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("mid_rst_addr",  {27'd0, ram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SPRAM_CTRL_INIT_EN
    wait_init("reinit_cycles");
`else
    tick();
`endif
    do_read(5'd9, INIT_EN ? 8'h00 : 8'h09);

`ifdef SPRAM_CTRL_INIT_EN
    // Reset at init address 12 must restart the fill from 0.
    do_write(5'd3, 8'h77);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int n = 0;
      while (ram_addr != 5'd12 && n < 100) begin
        tick();
        n++;
      end
    end
    check("init_at12", {27'd0, ram_addr}, 32'd12);
    rst_n = 1'b0;
    #1;
    check("init_rst_cs",   {31'd0, ram_cs}, 32'd0);
    check("init_rst_addr", {27'd0, ram_addr}, 32'd0);
    check("init_rst_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("init_restart_addr", {27'd0, ram_addr}, 32'd0);
    check("init_restart_cs",   {31'd0, ram_cs}, 32'd1);
    wait_init("init_restart_cycles");
    do_read(5'd3,  8'h00);
    do_read(5'd17, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spram_ctrl.md
SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 Port `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
REQ-002 Port `rst_n`: input, 1 bit. Asynchronous, active-low reset.
REQ-003 Port `req_valid`: input, 1 bit. A request is present.
REQ-004 Port `req_ready`: output, 1 bit. The controller can accept a request.
REQ-005 Port `req_wr`: input, 1 bit. 1 = write, 0 = read.
REQ-006 Port `req_addr`: input, 5 bits. Word address 0..31.
REQ-007 Port `req_wdata`: input, 8 bits. Write data.
REQ-008 Port `rsp_valid`: output, 1 bit. Read data is valid.
REQ-009 Port `rsp_ready`: input, 1 bit. The consumer accepts the read data.
REQ-010 Port `rsp_rdata`: output, 8 bits. Read data.
REQ-011 Port `init_done`: output, 1 bit. The RAM is available for requests.
REQ-012 Port `ram_cs`: output, 1 bit. Chip select to the 32x8 single-port RAM.
REQ-013 Port `ram_wr`: output, 1 bit. RAM write enable; 0 = read.
REQ-014 Port `ram_addr`: output, 5 bits. RAM address.
REQ-015 Port `ram_data`: inout, 8 bits. Shared RAM data bus.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, WRITE, RD1, RD2, RESP, plus INIT when configured.
REQ-017 A request SHALL be accepted only on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance, the block SHALL register req_wr, req_addr and req_wdata and go to WRITE if req_wr=1, else to RD1.
REQ-019 In WRITE, the block SHALL drive ram_cs=1, ram_wr=1, ram_addr=registered address, and ram_data=registered data for exactly one cycle, then go to IDLE.
REQ-020 In RD1 and RD2, the block SHALL drive ram_cs=1, ram_wr=0 and ram_addr=registered address; RD1 always goes to RD2.
REQ-021 On the edge leaving RD2, the block SHALL capture ram_data into rsp_rdata and go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1; the block SHALL stay in RESP with rsp_rdata stable until rsp_ready=1, then go to IDLE.
REQ-023 Read latency SHALL be: acceptance edge plus 3 cycles to rsp_valid=1 (RD1, RD2, then RESP).
REQ-024 The block SHALL drive ram_data only when ram_wr=1 (WRITE, INIT); in all other states ram_data SHALL be high-impedance on all 8 bits, so the bus is never contended.
REQ-025 In IDLE and RESP, ram_cs SHALL be 0.
REQ-026 ram_cs, ram_wr, ram_addr, the ram_data drive enable and rsp_valid SHALL be decoded from registered state only, with no combinational path from any request input.
REQ-027 Write throughput SHALL be one write every 2 cycles; read throughput SHALL be one read every 4 cycles when rsp_ready is held at 1.
REQ-028 A request presented while busy SHALL wait without loss; req_* may change freely after the acceptance edge.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force:
- state: IDLE, or INIT when configured
- ram_cs=0, ram_wr=0, ram_addr=0, ram_data high-impedance
- rsp_valid=0, rsp_rdata=0
- req_ready: 1 without INIT, 0 with INIT
- init counter: 0
REQ-030 Reset asserted mid-operation SHALL abandon any in-flight write, read or response without a ram_cs pulse, and SHALL restart INIT from address 0 when configured.

Configuration
REQ-031 Macro `SPRAM_CTRL_INIT_EN` SHALL control the INIT feature as follows:
- Defined: after reset the FSM enters INIT and writes 8'h00 to addresses 0..31, one per cycle, with ram_cs=1 and ram_wr=1.
- Defined: init_done=0 and req_ready=0 during INIT; after address 31 the FSM enters IDLE and init_done=1.
- Defined: the INIT sequence is exactly 32 cycles.
- Not defined: no INIT state exists, init_done is tied to 1, and IDLE follows reset directly.

Verification
REQ-032 Write then read: write addr 5 = 8'hA3, then read addr 5 -> rsp_valid=1 exactly 3 cycles after read acceptance, rsp_rdata=8'hA3, ram_data never driven by both sides.
REQ-033 Response backpressure: hold rsp_ready=0 for 10 cycles during a read of addr 31 = 8'h5C -> rsp_valid and rsp_rdata=8'h5C stay stable, req_ready=0, then one handshake returns the FSM to IDLE.
REQ-034 Back-to-back writes: req_valid held at 1 for writes to addr 0..31 with data=addr -> one write accepted every 2 cycles, and a readback of all 32 addresses matches.
REQ-035 Reset mid-read: assert rst_n=0 in RD2 -> ram_cs=0 and rsp_valid=0 immediately; the next read of the same address still returns the correct data.
REQ-036 With SPRAM_CTRL_INIT_EN defined: after reset release, init_done rises after 32 cycles, and reads of addr 0, 17 and 31 return 8'h00; a reset asserted at INIT address 12 restarts from 0.
